// File: rtl/program_write_buffer_if.sv
// Pixel-program input bus and SRAM write-slot bus of the program write buffer.
// master = copy engine / SRAM controller side, slave = the buffer itself.
interface program_write_buffer_if #(
  parameter int ADDR_W = 20
);
  logic [9:0]        program_x;
  logic [9:0]        program_y;
  logic [15:0]       program_data;
  logic              program_write;
  logic              program_ready;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output program_x, program_y, program_data, program_write, wr_ready,
    input  program_ready, wr_valid, wr_addr, wr_data
  );

  modport slave (
    input  program_x, program_y, program_data, program_write, wr_ready,
    output program_ready, wr_valid, wr_addr, wr_data
  );
endinterface

// File: rtl/program_write_buffer.sv
// Validates copy-engine pixels, maps (x,y) into the back frame's SRAM address space and
// queues them (input stage -> FIFO -> registered head) for the SRAM controller write slot.
module program_write_buffer #(
  parameter int DEPTH    = 16,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480,
  parameter int ADDR_W   = 20
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   current_frame,
  program_write_buffer_if.slave  bus,
  output logic                   empty,
  output logic [15:0]            drop_count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OFF_W = ADDR_W - 1;
  localparam int ENT_W = ADDR_W + 16;
  localparam logic [9:0] X_LIM = 10'(SCREEN_W);
  localparam logic [9:0] Y_LIM = 10'(SCREEN_H);

  logic              stage_valid;
  logic [ADDR_W-1:0] stage_addr;
  logic [15:0]       stage_data;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  mem_count;
  logic [CNT_W-1:0]  occupancy;
  logic [OFF_W-1:0]  line_base;
  logic [OFF_W-1:0]  pix_off;
  logic              in_range;
  logic              accept;
  logic              reject;
  logic              load_out;

  // y*640 as two shifts; the largest on-screen offset (307199) fits in 19 bits
  assign line_base = (OFF_W'(bus.program_y) << 9) + (OFF_W'(bus.program_y) << 7);
  assign pix_off   = line_base + OFF_W'(bus.program_x);
  assign in_range  = (bus.program_x < X_LIM) && (bus.program_y < Y_LIM);

  // Every held pixel counts against DEPTH: input stage, FIFO body and output head
  assign occupancy = mem_count + CNT_W'(bus.wr_valid) + CNT_W'(stage_valid);
  assign bus.program_ready = occupancy < CNT_W'(DEPTH);

  assign accept   = bus.program_write && bus.program_ready && in_range;
  assign reject   = bus.program_write && !accept;
  assign load_out = (mem_count != '0) && (!bus.wr_valid || bus.wr_ready);
  assign empty    = !stage_valid && (mem_count == '0) && !bus.wr_valid;

  always_ff @(posedge clk) begin
    if (stage_valid) mem[wr_ptr] <= {stage_addr, stage_data};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid  <= 1'b0;
      stage_addr   <= '0;
      stage_data   <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      mem_count    <= '0;
      bus.wr_valid <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= '0;
      drop_count   <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_addr <= {~current_frame, pix_off};
        stage_data <= bus.program_data;
      end

      if (stage_valid) wr_ptr <= wr_ptr + 1'b1;

      // Head only reloads when empty or being consumed, so it stays stable under backpressure
      if (load_out) begin
        {bus.wr_addr, bus.wr_data} <= mem[rd_ptr];
        rd_ptr       <= rd_ptr + 1'b1;
        bus.wr_valid <= 1'b1;
      end else if (bus.wr_valid && bus.wr_ready) begin
        bus.wr_valid <= 1'b0;
      end

      case ({stage_valid, load_out})
        2'b10:   mem_count <= mem_count + 1'b1;
        2'b01:   mem_count <= mem_count - 1'b1;
        default: mem_count <= mem_count;
      endcase

      if (reject && (drop_count != 16'hFFFF)) drop_count <= drop_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_program_write_buffer.sv
// Directed bench for program_write_buffer: latency, backpressure/drops, range limits,
// frame-bit sampling and mid-operation reset, with hand-computed expected values.
module tb_program_write_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        current_frame;
  logic        empty;
  logic [15:0] drop_count;
  int          n_cmp = 0;
  int          n_err = 0;

  program_write_buffer_if #(.ADDR_W(20)) bus ();

  program_write_buffer #(
    .DEPTH(16), .SCREEN_W(640), .SCREEN_H(480), .ADDR_W(20)
  ) u_dut (
    .clk           (clk),
    .reset         (reset),
    .current_frame (current_frame),
    .bus           (bus.slave),
    .empty         (empty),
    .drop_count    (drop_count)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset             = 1'b1;
    bus.program_write = 1'b0;
    bus.wr_ready      = 1'b0;
    current_frame     = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Drives one strobe for a single edge; consecutive calls give back-to-back strobes
  task automatic send(input logic [9:0] x, input logic [9:0] y, input logic [15:0] d);
    bus.program_x     = x;
    bus.program_y     = y;
    bus.program_data  = d;
    bus.program_write = 1'b1;
    @(negedge clk);
    bus.program_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset             = 1'b1;
    current_frame     = 1'b0;
    bus.program_x     = '0;
    bus.program_y     = '0;
    bus.program_data  = '0;
    bus.program_write = 1'b0;
    bus.wr_ready      = 1'b0;
    do_reset();

    // Reset state
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_wr_valid", 32'(bus.wr_valid), 32'd0);
    check_val("rst_ready", 32'(bus.program_ready), 32'd1);
    check_val("rst_drop", 32'(drop_count), 32'd0);

    // Single pixel latency and address mapping
    send(10'd5, 10'd2, 16'hF800);
    check_val("lat_n0_valid", 32'(bus.wr_valid), 32'd0);
    check_val("lat_n0_empty", 32'(empty), 32'd0);
    @(negedge clk);
    check_val("lat_n1_valid", 32'(bus.wr_valid), 32'd0);
    @(negedge clk);
    check_val("lat_n2_valid", 32'(bus.wr_valid), 32'd1);
    check_val("lat_addr", 32'(bus.wr_addr), 32'h80505);
    check_val("lat_data", 32'(bus.wr_data), 32'hF800);
    bus.wr_ready = 1'b1;
    @(negedge clk);
    bus.wr_ready = 1'b0;
    check_val("pop_valid", 32'(bus.wr_valid), 32'd0);
    check_val("pop_empty", 32'(empty), 32'd1);

    // Backpressure: 20 strobes into a 16-deep buffer
    do_reset();
    for (int i = 0; i < 20; i++) begin
      if (i == 15) check_val("ready_before_16th", 32'(bus.program_ready), 32'd1);
      if (i == 16) check_val("ready_after_16", 32'(bus.program_ready), 32'd0);
      send(10'(i), 10'd0, 16'h1000 + 16'(i));
    end
    @(negedge clk);
    @(negedge clk);
    check_val("full_drop", 32'(drop_count), 32'd4);
    check_val("full_ready", 32'(bus.program_ready), 32'd0);
    check_val("full_head_stable", 32'(bus.wr_addr), 32'h80000);
    bus.wr_ready = 1'b1;
    for (int k = 0; k < 16; k++) begin
      check_val("drain_valid", 32'(bus.wr_valid), 32'd1);
      check_val("drain_addr", 32'(bus.wr_addr), 32'h80000 + 32'(k));
      check_val("drain_data", 32'(bus.wr_data), 32'h1000 + 32'(k));
      @(negedge clk);
    end
    bus.wr_ready = 1'b0;
    check_val("drain_done_valid", 32'(bus.wr_valid), 32'd0);
    check_val("drain_done_empty", 32'(empty), 32'd1);

    // Off-screen coordinates and the far corner
    do_reset();
    send(10'd640, 10'd0, 16'hAAAA);
    send(10'd0, 10'd480, 16'hBBBB);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("oob_drop", 32'(drop_count), 32'd2);
    check_val("oob_valid", 32'(bus.wr_valid), 32'd0);
    check_val("oob_empty", 32'(empty), 32'd1);
    current_frame = 1'b1;
    send(10'd639, 10'd479, 16'h07E0);
    @(negedge clk);
    @(negedge clk);
    check_val("corner_valid", 32'(bus.wr_valid), 32'd1);
    check_val("corner_addr", 32'(bus.wr_addr), 32'h4AFFF);
    check_val("corner_data", 32'(bus.wr_data), 32'h07E0);

    // Frame bit captured at acceptance, not at drain
    do_reset();
    send(10'd1, 10'd1, 16'h1111);
    current_frame = 1'b1;
    send(10'd2, 10'd1, 16'h2222);
    @(negedge clk);
    check_val("frame_a_addr", 32'(bus.wr_addr), 32'h80281);
    check_val("frame_a_data", 32'(bus.wr_data), 32'h1111);
    bus.wr_ready = 1'b1;
    @(negedge clk);
    bus.wr_ready = 1'b0;
    check_val("frame_b_valid", 32'(bus.wr_valid), 32'd1);
    check_val("frame_b_addr", 32'(bus.wr_addr), 32'h00282);
    check_val("frame_b_data", 32'(bus.wr_data), 32'h2222);

    // Reset with pixels queued
    do_reset();
    for (int i = 0; i < 8; i++) send(10'(i), 10'd3, 16'h3000 + 16'(i));
    send(10'd700, 10'd0, 16'hDEAD);
    @(negedge clk);
    @(negedge clk);
    check_val("pre_rst_drop", 32'(drop_count), 32'd1);
    check_val("pre_rst_valid", 32'(bus.wr_valid), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_val("mid_rst_valid", 32'(bus.wr_valid), 32'd0);
    check_val("mid_rst_empty", 32'(empty), 32'd1);
    check_val("mid_rst_drop", 32'(drop_count), 32'd0);
    check_val("mid_rst_ready", 32'(bus.program_ready), 32'd1);
    send(10'd9, 10'd0, 16'h4444);
    @(negedge clk);
    @(negedge clk);
    check_val("post_rst_addr", 32'(bus.wr_addr), 32'h80009);
    check_val("post_rst_data", 32'(bus.wr_data), 32'h4444);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
